// File: rtl/mt_rand_arbiter.sv
// Buffers a Mersenne-twister word stream and shares it round-robin
// among NUM_REQ consumers, after a warm-up discard phase.
module mt_rand_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FIFO_AW     = 4,
  parameter int DISCARD_CNT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [31:0]        rng_data,
  input  logic               rng_valid,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        gnt_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        drop_count,
  output logic               warm
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int RW    = $clog2(NUM_REQ);
  localparam int DW    =
    (DISCARD_CNT < 2) ? 1 : $clog2(DISCARD_CNT);

  localparam logic [FIFO_AW:0] FULL_LVL =
    (FIFO_AW+1)'(DEPTH);
  localparam logic [DW-1:0] DISC_LAST =
    DW'(DISCARD_CNT - 1);
  localparam logic [RW-1:0] RR_LAST =
    RW'(NUM_REQ - 1);
  localparam logic [RW:0] NREQ_W =
    (RW+1)'(NUM_REQ);

  typedef enum logic {
    S_DISCARD = 1'b0,
    S_RUN     = 1'b1
  } state_e;

  localparam state_e S_INIT =
    (DISCARD_CNT == 0) ? S_RUN : S_DISCARD;

  state_e state_q, state_d;

  logic [DW-1:0]      disc_q, disc_d;
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW:0]   lvl_q, lvl_d;
  logic [15:0]        drop_q, drop_d;
  logic [RW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]        gdat_q, gdat_d;
  logic [31:0]        mem_q [DEPTH];

  logic          disc_last;
  logic          run;
  logic          full;
  logic          empty;
  logic          found;
  logic [RW-1:0] win;
  logic          pop;
  logic          push;
  logic          drop;
  logic [31:0]   head;

  assign disc_last = (disc_q == DISC_LAST);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      flush: begin
        state_d = S_INIT;
      end
      (!flush && state_q == S_DISCARD &&
       rng_valid && disc_last): begin
        state_d = S_RUN;
      end
      default: ;
    endcase
  end

  // FSM: outputs
  always_comb begin
    warm = (state_q == S_RUN);
  end

  // Warm-up counter advances on valid words only
  always_comb begin
    disc_d = disc_q;
    if (flush) begin
      disc_d = '0;
    end else if (state_q == S_DISCARD && rng_valid) begin
      disc_d = disc_last ? '0 : disc_q + 1'b1;
    end
  end

  // Round-robin search starting at rr_q
  always_comb begin
    logic [RW:0]   sum;
    logic [RW-1:0] idx;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (RW+1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[RW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign run   = (state_q == S_RUN) && !flush;
  assign full  = (lvl_q == FULL_LVL);
  assign empty = (lvl_q == '0);
  assign head  = mem_q[rd_q];

  assign pop  = run && !empty && found;
  assign push = run && rng_valid && (!full || pop);
  assign drop = run && rng_valid && full && !pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_comb begin
    gnt_d  = '0;
    gdat_d = gdat_q;
    rr_d   = rr_q;
    if (pop) begin
      gnt_d  = NUM_REQ'(1) << win;
      gdat_d = head;
      rr_d   = (win == RR_LAST) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disc_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      drop_q <= '0;
      rr_q   <= '0;
      gnt_q  <= '0;
      gdat_q <= '0;
    end else begin
      disc_q <= disc_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      drop_q <= drop_d;
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      gdat_q <= gdat_d;
    end
  end

  // Storage carries no reset; lvl_q alone defines what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= rng_data;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_data   = gdat_q;
  assign fifo_level = lvl_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mt_rand_arbiter.sv
// Directed bench for mt_rand_arbiter: warm-up, round-robin,
// full-FIFO push/pop, latency, flush, async reset, saturation.
module tb_mt_rand_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rng_data = '0;
  logic        rng_valid = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic [31:0] gnt_data;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;
  logic        warm;

  int n_cmp = 0;
  int n_err = 0;

  mt_rand_arbiter #(
    .NUM_REQ(4),
    .FIFO_AW(4),
    .DISCARD_CNT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .rng_data(rng_data),
    .rng_valid(rng_valid),
    .req(req),
    .gnt(gnt),
    .gnt_data(gnt_data),
    .fifo_level(fifo_level),
    .drop_count(drop_count),
    .warm(warm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt, gnt_data, fifo_level, drop_count, warm} !== '0) begin
      n_err++;
      $display("FAIL reset_outs got gnt=%b dat=%h lvl=%0d drop=%0d warm=%b want all 0",
               gnt, gnt_data, fifo_level, drop_count, warm);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_warmup();
    int el;
    int ed;
    for (int w = 1; w <= 40; w++) begin
      rng_valid = 1'b1;
      rng_data  = 32'(w);
      tick();
      el = (w <= 16) ? 0 : ((w - 16 > 16) ? 16 : w - 16);
      ed = (w > 32) ? w - 32 : 0;
      n_cmp++;
      if (warm !== (w >= 16)) begin
        n_err++;
        $display("FAIL warm w=%0d got %b want %b", w, warm, (w >= 16));
      end
      n_cmp++;
      if (fifo_level !== 5'(el)) begin
        n_err++;
        $display("FAIL warm_lvl w=%0d got %0d want %0d", w, fifo_level, el);
      end
      n_cmp++;
      if (drop_count !== 16'(ed)) begin
        n_err++;
        $display("FAIL warm_drop w=%0d got %0d want %0d", w, drop_count, ed);
      end
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_err++;
        $display("FAIL warm_gnt w=%0d got %b want 0000", w, gnt);
      end
    end
    rng_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    req = 4'b1111;
    for (int k = 1; k <= 16; k++) begin
      tick();
      eg = 4'b0001 << ((k - 1) % 4);
      n_cmp++;
      if (gnt !== eg || gnt_data !== 32'(16 + k)) begin
        n_err++;
        $display("FAIL rr k=%0d got gnt=%b dat=%0d want gnt=%b dat=%0d",
                 k, gnt, gnt_data, eg, 16 + k);
      end
      n_cmp++;
      if (fifo_level !== 5'(16 - k)) begin
        n_err++;
        $display("FAIL rr_lvl k=%0d got %0d want %0d", k, fifo_level, 16 - k);
      end
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_data !== 32'd32 || fifo_level !== 5'd0) begin
      n_err++;
      $display("FAIL rr_empty got gnt=%b dat=%0d lvl=%0d want 0000/32/0",
               gnt, gnt_data, fifo_level);
    end
    req = 4'b0000;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] ed;
    for (int i = 0; i < 16; i++) begin
      rng_valid = 1'b1;
      rng_data  = 32'(100 + i);
      tick();
    end
    n_cmp++;
    if (fifo_level !== 5'd16) begin
      n_err++;
      $display("FAIL full_fill got %0d want 16", fifo_level);
    end
    rng_data = 32'd200;
    req      = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_data !== 32'd100) begin
      n_err++;
      $display("FAIL full_pp_gnt got %b/%0d want 0010/100", gnt, gnt_data);
    end
    n_cmp++;
    if (fifo_level !== 5'd16 || drop_count !== 16'd8) begin
      n_err++;
      $display("FAIL full_pp_lvl got lvl=%0d drop=%0d want 16/8",
               fifo_level, drop_count);
    end
    req      = 4'b0000;
    rng_data = 32'd201;
    tick();
    n_cmp++;
    if (drop_count !== 16'd9 || fifo_level !== 5'd16 || gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL full_drop got drop=%0d lvl=%0d gnt=%b want 9/16/0000",
               drop_count, fifo_level, gnt);
    end
    rng_valid = 1'b0;
    req       = 4'b1000;
    for (int k = 0; k < 16; k++) begin
      tick();
      ed = (k < 15) ? 32'(101 + k) : 32'd200;
      n_cmp++;
      if (gnt !== 4'b1000 || gnt_data !== ed ||
          fifo_level !== 5'(15 - k)) begin
        n_err++;
        $display("FAIL sole k=%0d got %b/%0d/%0d want 1000/%0d/%0d",
                 k, gnt, gnt_data, fifo_level, ed, 15 - k);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_latency();
    req       = 4'b0100;
    rng_valid = 1'b1;
    rng_data  = 32'hDEADBEEF;
    tick();
    rng_valid = 1'b0;
    n_cmp++;
    if (gnt !== 4'b0000 || fifo_level !== 5'd1) begin
      n_err++;
      $display("FAIL lat_t1 got gnt=%b lvl=%0d want 0000/1", gnt, fifo_level);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL lat_t2 got %b/%h want 0100/deadbeef", gnt, gnt_data);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || fifo_level !== 5'd0) begin
      n_err++;
      $display("FAIL lat_t3 got gnt=%b lvl=%0d want 0000/0", gnt, fifo_level);
    end
    req = 4'b0000;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) begin
      rng_valid = 1'b1;
      rng_data  = 32'(300 + i);
      tick();
    end
    rng_valid = 1'b0;
    req       = 4'b1111;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || gnt_data !== 32'd300 || fifo_level !== 5'd9) begin
      n_err++;
      $display("FAIL fl_pre got %b/%0d/%0d want 1000/300/9",
               gnt, gnt_data, fifo_level);
    end
    flush     = 1'b1;
    rng_valid = 1'b1;
    rng_data  = 32'd999;
    tick();
    flush = 1'b0;
    req   = 4'b0000;
    n_cmp++;
    if (gnt !== 4'b0000 || fifo_level !== 5'd0 || warm !== 1'b0) begin
      n_err++;
      $display("FAIL fl_clr got gnt=%b lvl=%0d warm=%b want 0000/0/0",
               gnt, fifo_level, warm);
    end
    n_cmp++;
    if (drop_count !== 16'd9 || gnt_data !== 32'd300) begin
      n_err++;
      $display("FAIL fl_keep got drop=%0d dat=%0d want 9/300",
               drop_count, gnt_data);
    end
    for (int i = 0; i < 16; i++) begin
      rng_data = 32'(400 + i);
      tick();
      n_cmp++;
      if (warm !== (i == 15) || fifo_level !== 5'd0 ||
          drop_count !== 16'd9) begin
        n_err++;
        $display("FAIL fl_disc i=%0d got warm=%b lvl=%0d drop=%0d",
                 i, warm, fifo_level, drop_count);
      end
    end
    rng_data = 32'd416;
    tick();
    rng_valid = 1'b0;
    n_cmp++;
    if (fifo_level !== 5'd1) begin
      n_err++;
      $display("FAIL fl_first got %0d want 1", fifo_level);
    end
    req = 4'b0001;
    tick();
    req = 4'b0000;
    n_cmp++;
    if (gnt !== 4'b0001 || gnt_data !== 32'd416) begin
      n_err++;
      $display("FAIL fl_gnt got %b/%0d want 0001/416", gnt, gnt_data);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      rng_valid = 1'b1;
      rng_data  = 32'(500 + i);
      tick();
    end
    rng_valid = 1'b0;
    req       = 4'b1111;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_data !== 32'd500) begin
      n_err++;
      $display("FAIL ar_pre got %b/%0d want 0010/500", gnt, gnt_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, gnt_data, fifo_level, drop_count, warm} !== '0) begin
      n_err++;
      $display("FAIL ar_async got gnt=%b dat=%h lvl=%0d drop=%0d warm=%b want all 0",
               gnt, gnt_data, fifo_level, drop_count, warm);
    end
    req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    test_warmup();
  endtask

  task automatic test_saturate();
    rng_valid = 1'b1;
    rng_data  = 32'h5A5A5A5A;
    repeat (65534 - 8) tick();
    n_cmp++;
    if (drop_count !== 16'hFFFE) begin
      n_err++;
      $display("FAIL sat_pre got %h want fffe", drop_count);
    end
    tick();
    n_cmp++;
    if (drop_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hit got %h want ffff", drop_count);
    end
    repeat (3) tick();
    n_cmp++;
    if (drop_count !== 16'hFFFF || fifo_level !== 5'd16) begin
      n_err++;
      $display("FAIL sat_hold got drop=%h lvl=%0d want ffff/16",
               drop_count, fifo_level);
    end
    rng_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_round_robin();
    test_full_push_pop();
    test_latency();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
